// File: rtl/pending_priority_encoder_pkg.sv
// Shared types and constants for the pending-event priority encoder.
// Selection mode encodings and the grant state machine states.
package pending_priority_encoder_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/priority_pick.sv
// Combinational circular search: first set bit of vec at or after start, wrapping.
// Zero latency; no handshake.
module priority_pick #(
   parameter  int NUM_INPUTS  = 8,
   localparam int INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0]  vec,
   input  logic [INDEX_WIDTH-1:0] start,
   output logic                   found,
   output logic [INDEX_WIDTH-1:0] index
);

   logic [INDEX_WIDTH:0] pos;

   // Walk from the far end back toward start so the nearest hit is written last.
   always_comb begin
      found = 1'b0;
      index = '0;
      pos   = '0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         pos = {1'b0, start} + (INDEX_WIDTH + 1)'(k);
         if (pos >= (INDEX_WIDTH + 1)'(NUM_INPUTS)) begin
            pos = pos - (INDEX_WIDTH + 1)'(NUM_INPUTS);
         end
         if (vec[pos[INDEX_WIDTH-1:0]]) begin
            found = 1'b1;
            index = pos[INDEX_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/pending_priority_encoder.sv
// Captures request rising edges into sticky pending bits and grants one index at a time.
// Valid two cycles after a request edge; grant held until Ack, min grant period two cycles.
module pending_priority_encoder
   import pending_priority_encoder_pkg::*;
#(
   parameter  int NUM_INPUTS  = 8,
   localparam int INDEX_WIDTH = $clog2(NUM_INPUTS)
) (
   input  logic                   Clock_In,
   input  logic                   Reset_In,
   input  logic                   Enable_In,
   input  logic                   Mode_In,
   input  logic [NUM_INPUTS-1:0]  Request_In,
   input  logic                   Clear_In,
   input  logic                   Ack_In,
   output logic                   Valid_Out,
   output logic [INDEX_WIDTH-1:0] Index_Out,
   output logic [NUM_INPUTS-1:0]  Pending_Out,
   output logic [INDEX_WIDTH:0]   Pending_Count_Out,
   output logic                   Overrun_Out
);

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_INPUTS - 1);

   state_t                  state_q, state_d;
   logic                    valid_d;
   logic [INDEX_WIDTH-1:0]  index_d;
   logic [INDEX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
   logic [NUM_INPUTS-1:0]   request_q;
   logic [NUM_INPUTS-1:0]   pending_q, pending_d;
   logic                    overrun_q, overrun_d;
   logic [NUM_INPUTS-1:0]   rise;
   logic [NUM_INPUTS-1:0]   ack_mask;
   logic                    ack_fire;
   logic [INDEX_WIDTH-1:0]  pick_start;
   logic                    pick_found;
   logic [INDEX_WIDTH-1:0]  pick_index;

   assign rise     = Request_In & ~request_q;
   assign ack_fire = Valid_Out & Ack_In;
   assign ack_mask = ack_fire ? (NUM_INPUTS'(1) << Index_Out) : '0;

   // A rise on the bit being acked re-arms it rather than counting as an overrun.
   assign pending_d = Clear_In ? '0 : ((pending_q & ~ack_mask) | rise);
   assign overrun_d = Clear_In ? 1'b0 : (overrun_q | (|(rise & pending_q & ~ack_mask)));

   assign pick_start = (Mode_In == MODE_RR)
                     ? ((rr_ptr_q == LAST_IDX) ? '0 : rr_ptr_q + INDEX_WIDTH'(1))
                     : '0;

   priority_pick #(.NUM_INPUTS(NUM_INPUTS)) u_pick (
      .vec   (pending_q),
      .start (pick_start),
      .found (pick_found),
      .index (pick_index)
   );

   always_comb begin
      state_d  = state_q;
      valid_d  = Valid_Out;
      index_d  = Index_Out;
      rr_ptr_d = rr_ptr_q;
      if (Clear_In) begin
         state_d = ST_IDLE;
         valid_d = 1'b0;
         index_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Enable_In && pick_found) begin
                  state_d = ST_GRANT;
                  valid_d = 1'b1;
                  index_d = pick_index;
               end
            end
            ST_GRANT: begin
               if (Ack_In) begin
                  state_d  = ST_IDLE;
                  valid_d  = 1'b0;
                  index_d  = '0;
                  rr_ptr_d = Index_Out;
               end
            end
         endcase
      end
   end

   always_ff @(posedge Clock_In or negedge Reset_In) begin
      if (!Reset_In) begin
         state_q   <= ST_IDLE;
         Valid_Out <= 1'b0;
         Index_Out <= '0;
         rr_ptr_q  <= LAST_IDX;
         request_q <= '0;
         pending_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         Valid_Out <= valid_d;
         Index_Out <= index_d;
         rr_ptr_q  <= rr_ptr_d;
         request_q <= Request_In;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      Pending_Count_Out = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         Pending_Count_Out = Pending_Count_Out + {{INDEX_WIDTH{1'b0}}, pending_q[i]};
      end
   end

   assign Pending_Out = pending_q;
   assign Overrun_Out = overrun_q;

endmodule

// File: doc/pending_priority_encoder.md
# pending_priority_encoder

Parametrised, registered successor to the 8-3 priority encoder. It captures rising edges on `NUM_INPUTS` request lines into a sticky pending register. It then presents one encoded index at a time under a Valid/Ack handshake, using either fixed priority (index 0 highest) or round-robin selection. It sits between interrupt/event sources and a single consumer that services one event per handshake.

## Interface
Parameters:
- `NUM_INPUTS`, default 8, number of request lines (2..64).
- `INDEX_WIDTH`, localparam `$clog2(NUM_INPUTS)`, width of the encoded index.

Ports:
- `Clock_In`, input, 1, single clock; all state updates on its rising edge.
- `Reset_In`, input, 1, asynchronous, active-low reset.
- `Enable_In`, input, 1, when low, no new grant is started; pending capture continues.
- `Mode_In`, input, 1, 0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- `Request_In`, input, `NUM_INPUTS`, request lines; a rising edge sets the matching pending bit.
- `Clear_In`, input, 1, synchronous flush of the pending register, the overrun flag and any grant.
- `Ack_In`, input, 1, consumer accepts the current index.
- `Valid_Out`, output, 1, `Index_Out` is valid and is held stable until acknowledged.
- `Index_Out`, output, `INDEX_WIDTH`, encoded granted index; 0 when `Valid_Out` is low.
- `Pending_Out`, output, `NUM_INPUTS`, current pending register.
- `Pending_Count_Out`, output, `INDEX_WIDTH+1`, population count of `Pending_Out`.
- `Overrun_Out`, output, 1, sticky flag: a rising edge arrived on an already-pending bit.

## Operation
- Edge detect: `Request_Q` register. A bit rises when `Request_In[i] & ~Request_Q[i]`. Held-high requests set pending only once.
- Pending update per cycle, in priority order:
  - `Clear_In` zeroes pending and drops edges seen that cycle.
  - Otherwise, pending = (pending & ~ack_mask) | rise.
  - `ack_mask` is the one-hot of `Index_Out` when `Valid_Out & Ack_In`.
  - A rise on the bit being acked in the same cycle leaves it set and is not an overrun.
- Overrun: set when `rise[i] & pending[i]` and bit i is not being acked that cycle. Cleared only by `Clear_In` or reset.
- State machine:
  - IDLE: if `Enable_In` and pending ≠ 0 (registered value), pick an index, register it into `Index_Out`, set `Valid_Out`, and go to GRANT.
  - GRANT: hold `Index_Out`/`Valid_Out` stable. On `Ack_In`, drop `Valid_Out`, zero `Index_Out`, update the round-robin pointer and return to IDLE.
  - `Clear_In` in any state: go to IDLE and drop `Valid_Out` next cycle. `Clear_In` beats `Ack_In`; the pointer is not updated.
- Fixed mode: lowest-numbered pending bit wins.
- Round-robin mode: search starts at pointer+1 and wraps modulo `NUM_INPUTS`. The pointer holds the last granted index, wrap from `NUM_INPUTS-1` goes to 0, and the pointer is only updated on an acked grant.
- Changing `Mode_In` during GRANT has no effect until the next IDLE evaluation.
- `Enable_In` low during GRANT does not withdraw the current grant.

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE
  - `Valid_Out`=0, `Index_Out`=0
  - `Pending_Out`=0, `Pending_Count_Out`=0, `Overrun_Out`=0
  - `Request_Q`=0
  - RR pointer=`NUM_INPUTS-1`, so the first RR search starts at 0.
- Latency: a request rising in cycle t sets pending after edge t; `Valid_Out` rises after edge t+1 (2 cycles).
- Ack sampled high at edge e drops `Valid_Out` after e. The next grant can appear after e+1, so the minimum grant period is 2 cycles.
- Reset asserted mid-grant drops `Valid_Out` immediately and discards all pending state.
- `Pending_Count_Out` is combinational from the pending register only, so it is glitch-free relative to the clock.

## Structure
- Package `pending_priority_encoder_pkg`:
  - state enum `{ST_IDLE, ST_GRANT}`
  - mode constants `MODE_FIXED=1'b0`, `MODE_RR=1'b1`
- Sub-module `priority_pick`: purely combinational, parametrised by `NUM_INPUTS`.
  - Inputs: vector and start index.
  - Outputs: found flag and first-set index at or after start, with wrap.
  - Fixed mode uses start=0; RR uses pointer+1.
  - Instantiated once.

## Test plan
- Reset, then pulse `Request_In`=8'b1010_0100 with `Mode_In`=0 and Ack one cycle after each Valid: indices 2, 5, 7 in order, `Pending_Count_Out` goes 3→2→1→0, first Valid 2 cycles after the pulse.
- `Mode_In`=1, hold all 8 bits pending, ack each grant: indices 0,1,...,7, then the pointer wraps; re-pending bits 0 and 7 after grant 7 gives 0 then 7.
- Hold grant (no Ack) while pulsing the already-pending bit: `Overrun_Out`=1 and stays 1 until `Clear_In`; the same pulse coincident with Ack of that bit gives no overrun and a new grant of the same index.
- `Clear_In` concurrent with Ack and a new request: `Valid_Out`=0, pending=0, count 0, RR pointer unchanged, new request dropped.
- `Enable_In`=0 with requests pending: no Valid, pending accumulates; raising Enable gives Valid on the next cycle. An async reset mid-GRANT zeroes all outputs immediately.
